// File: rtl/sub_circuit_pkg.sv
// Shared types and constants for the 3-input sub-circuit self-test checker.
package sub_circuit_pkg;

    localparam int unsigned IDX_W       = 3;
    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned CNT_W       = 4;

    // Bit i is the golden d for vector {a,b,c} = i, encoding d = ~(a|b) & c.
    localparam logic [NUM_VECTORS-1:0] EXPECTED_DEFAULT = 8'h02;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/sub_circuit_checker.sv
// Sweeps all 8 {a,b,c} vectors onto the sub-circuit, samples d after a settle time
// and accumulates mismatches against a golden truth table.
module sub_circuit_checker
    import sub_circuit_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0] EXPECTED      = EXPECTED_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   d_in,
    output logic                   a_out,
    output logic                   b_out,
    output logic                   c_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       err_count,
    output logic [NUM_VECTORS-1:0] fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            c_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A start in DONE discards the previous results on the same edge.
                    if (start) begin
                        idx_q                 <= '0;
                        {a_out, b_out, c_out} <= 3'b000;
                        err_count             <= '0;
                        fail_vec              <= '0;
                        done                  <= 1'b0;
                        cnt_q                 <= '0;
                        busy                  <= 1'b1;
                        state_q               <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (d_in != EXPECTED[idx_q]) begin
                        fail_vec[idx_q] <= 1'b1;
                        err_count       <= err_count + 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        {a_out, b_out, c_out} <= 3'b000;
                        busy                  <= 1'b0;
                        done                  <= 1'b1;
                        state_q               <= DONE;
                    end else begin
                        idx_q                 <= idx_q + 1'b1;
                        {a_out, b_out, c_out} <= idx_q + 1'b1;
                        cnt_q                 <= '0;
                        state_q               <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_sub_circuit_checker.sv
// Directed bench for sub_circuit_checker: table-driven sweeps against several d_in
// sources plus hand-written reset, ignored-start and restart-from-DONE sequences.
module tb_sub_circuit_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       d_in;
    logic       a_out, b_out, c_out;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    int checks = 0;
    int errors = 0;
    int mode   = 0;  // 0 good circuit, 1 tie 0, 2 tie 1, 3 ~(a|b)

    always #5 clk = ~clk;

    always_comb begin
        d_in = 1'b0;
        case (mode)
            0:       d_in = ~(a_out | b_out) & c_out;
            1:       d_in = 1'b0;
            2:       d_in = 1'b1;
            3:       d_in = ~(a_out | b_out);
            default: d_in = 1'b0;
        endcase
    end

    sub_circuit_checker #(
        .SETTLE_CYCLES(2),
        .EXPECTED     (8'h02)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .d_in     (d_in),
        .a_out    (a_out),
        .b_out    (b_out),
        .c_out    (c_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_vec (fail_vec)
    );

    typedef struct {
        int         mode;
        logic [3:0] err;
        logic [7:0] fail;
        logic       pass;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " abc"}, {a_out, b_out, c_out}, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, done, 0);
        chk({name, " pass"}, pass, 0);
        chk({name, " err_count"}, err_count, 0);
        chk({name, " fail_vec"}, fail_vec, 0);
    endtask

    // Pulse start so it is seen on exactly one rising edge; returns #1 after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows a sweep from the accepting edge until done, checking busy and the
    // driven vector every cycle. poke_k >= 0 re-pulses start at that cycle.
    task automatic run_sweep(input string name, input int poke_k, output int cycles);
        int k;
        bit seq_ok;
        k      = 0;
        seq_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (done || k >= 100) break;
            if (!busy || pass || ({a_out, b_out, c_out} != 3'(k / 3))) seq_ok = 1'b0;
            if (k == poke_k) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            k++;
        end
        chk({name, " vector sequence"}, seq_ok, 1);
        chk({name, " cycles to done"}, k, 24);
        chk({name, " busy after done"}, busy, 0);
        chk({name, " abc after done"}, {a_out, b_out, c_out}, 0);
        cycles = k;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{mode: 0, err: 4'd0, fail: 8'h00, pass: 1'b1};
        vecs[1] = '{mode: 1, err: 4'd1, fail: 8'h02, pass: 1'b0};
        vecs[2] = '{mode: 2, err: 4'd7, fail: 8'hFD, pass: 1'b0};
        vecs[3] = '{mode: 3, err: 4'd1, fail: 8'h01, pass: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("idle");

        foreach (vecs[i]) begin
            string nm;
            nm   = $sformatf("vec%0d", i);
            mode = vecs[i].mode;
            pulse_start();
            chk({nm, " busy at accept"}, busy, 1);
            chk({nm, " done cleared"}, done, 0);
            run_sweep(nm, -1, cyc);
            chk({nm, " done"}, done, 1);
            chk({nm, " err_count"}, err_count, vecs[i].err);
            chk({nm, " fail_vec"}, fail_vec, vecs[i].fail);
            chk({nm, " pass"}, pass, vecs[i].pass);
            repeat (3) @(posedge clk);
            #1 chk({nm, " results held"}, {done, err_count, fail_vec}, {1'b1, vecs[i].err, vecs[i].fail});
        end

        // Asynchronous reset in the middle of vector 4 with mismatches already recorded.
        mode = 2;
        pulse_start();
        repeat (12) @(posedge clk);
        #1 chk("pre-reset abc", {a_out, b_out, c_out}, 3'b100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid-sweep reset");
        @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        pulse_start();
        run_sweep("post-reset", -1, cyc);
        chk("post-reset pass", pass, 1);
        chk("post-reset err_count", err_count, 0);

        // Second start during the sweep must not restart it or disturb results.
        mode = 0;
        pulse_start();
        run_sweep("ignored start", 5, cyc);
        chk("ignored start pass", pass, 1);
        chk("ignored start fail_vec", fail_vec, 0);

        // Restart from DONE with tied-low d_in: results cleared on the accepting edge.
        mode = 1;
        pulse_start();
        chk("restart done cleared", done, 0);
        chk("restart err cleared", err_count, 0);
        chk("restart fail cleared", fail_vec, 0);
        chk("restart busy", busy, 1);
        run_sweep("restart", -1, cyc);
        chk("restart err_count", err_count, 1);
        chk("restart fail_vec", fail_vec, 8'h02);
        chk("restart pass", pass, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
